vga640x480_sync_rx: RTL and testbench
=====================================

Name: vga640x480_sync_rx

Overview:
Receive-side companion to the team's 640x480@60Hz sync generator. It samples incoming active-low hsync/vsync, rebuilds hpos/vpos and display_on, and measures line length, sync widths and lines per frame. It asserts locked only after consecutive frames match the expected timing. It is used as an on-chip timing checker and as the front end for capture/overlay logic.

Parameters:
H_DISPLAY, 640, active pixels per line
H_BACK, 48, clocks from hsync end to active video
H_FRONT, 16, clocks from active video end to hsync start
H_SYNC, 96, hsync pulse width in clocks
V_DISPLAY, 480, active lines per frame
V_TOP, 10, lines from active video end to vsync start
V_BOTTOM, 33, lines from vsync end to active video
V_SYNC, 2, vsync pulse width in lines
LOCK_FRAMES, 2, consecutive good frames required to lock (1..7)

Ports:
clk  in  1  pixel clock, 25.175 MHz
reset  in  1  asynchronous, active-low reset
hsync  in  1  horizontal sync, active low, synchronous to clk
vsync  in  1  vertical sync, active low, synchronous to clk
locked  out  1  timing has matched for LOCK_FRAMES consecutive frames
hpos  out  10  clocks since hsync leading edge
vpos  out  10  lines since vsync leading edge
display_on  out  1  reconstructed active-area flag
line_len  out  10  clocks in the last complete line
frame_lines  out  10  lines in the last complete frame
frame_start  out  1  one-clock pulse at frame boundary
timing_err  out  1  one-clock pulse on any violation while in VERIFY or LOCKED

Behaviour:
- Derived values: H_TOTAL = sum of the four H parameters (800). V_TOTAL = sum of the four V parameters (525).
- Reset (low, asynchronous):
  - Input registers hs_q, hs_qq, vs_q, vs_qq are set to 1, so no edge is detected at reset release.
  - All counters, all outputs and the FSM go to 0/SEARCH.
- Input stage: hs_q <= hsync; hs_qq <= hs_q; vs_q and vs_qq are pipelined the same way.
- Edge definitions:
  - hfall = hs_qq & ~hs_q; hrise = ~hs_qq & hs_q.
  - vfall and vrise are defined the same way on the vs_ registers.
- Horizontal counter hcnt (10 bits):
  - On hfall: hcnt <= 1 and line_len <= hcnt.
  - Otherwise: hcnt <= hcnt + 1, saturating at 1023.
  - hpos = hfall ? 0 : hcnt.
- Hsync width: hsw counts clocks with hs_q low. On hrise it is checked against H_SYNC and then cleared.
- Line error is raised on any of:
  - hfall with hcnt != H_TOTAL, except the first hfall after leaving SEARCH;
  - hrise with a width mismatch;
  - hcnt reaching 1023, which is a timeout.
- Vertical tracking:
  - vfall sets vpend.
  - A frame boundary is an hfall with vpend or vfall true, including both in the same cycle. On a boundary: vcnt <= 0, frame_lines <= vcnt + 1, frame_start pulses, vpend clears.
  - Any other hfall gives vcnt <= vcnt + 1, saturating at 1023. vpos = vcnt.
  - vcnt reaching 1023 is a timeout.
- Vsync width: vsw counts hfalls while vs_q is low. On vrise it is checked against V_SYNC and then cleared.
- A frame is good when, at its closing boundary, all of these hold: vcnt + 1 == V_TOTAL, no line error since its opening boundary, and no vsync width error.
- FSM states:
  - SEARCH: locked = 0. First boundary goes to VERIFY with good = 0.
  - VERIFY, at each boundary: a good frame gives good + 1, and reaching LOCK_FRAMES goes to LOCKED. A bad frame gives good = 0, timing_err pulses, state stays VERIFY.
  - LOCKED: any line error or bad frame goes to VERIFY with good = 0, and timing_err pulses in the detecting cycle.
  - Any state: a timeout goes to SEARCH and pulses timing_err, except when already in SEARCH.
- locked = (state == LOCKED). It is registered, so it changes one clock after the deciding event.
- display_on = locked & (H_SYNC+H_BACK <= hpos <= H_SYNC+H_BACK+H_DISPLAY-1) & (V_SYNC+V_BOTTOM <= vpos <= V_SYNC+V_BOTTOM+V_DISPLAY-1). With defaults this is hpos 144..783 and vpos 35..514.
- Simultaneous events: a bad line length and a boundary in the same cycle count as a bad frame, with a single timing_err pulse.

Test Plan:
- Nominal 800x525 stream (96-clock hsync, 2-line vsync) after reset -> line_len = 800, frame_lines = 525, locked rises 1 clock after the 3rd frame_start, then exactly 307200 display_on cycles per frame.
- While locked, one hsync pulse of 95 clocks -> timing_err pulse at that hrise, locked low 1 clock later, locked back after 2 further good frames.
- While locked, one 801-clock line -> line_len = 801, timing_err pulse, locked drops, frame_lines for that frame still reported.
- hsync held high after lock -> hpos saturates at 1023, timeout pulse, state SEARCH, locked = 0, display_on = 0.
- Frame with a 3-line vsync -> frame judged bad at the next boundary, locked never asserted during the run.
- reset pulsed low mid-frame while locked -> all outputs 0 immediately (asynchronous); relock requires 1 boundary plus 2 good frames.

Source files
------------

// File: rtl/vga640x480_sync_rx.sv
// Receive-side 640x480 timing checker: rebuilds hpos/vpos/display_on from incoming
// active-low syncs, measures line/frame timing and locks after consecutive good frames.
module vga640x480_sync_rx #(
  parameter int H_DISPLAY   = 640,
  parameter int H_BACK      = 48,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int V_DISPLAY   = 480,
  parameter int V_TOP       = 10,
  parameter int V_BOTTOM    = 33,
  parameter int V_SYNC      = 2,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  output logic       locked,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       display_on,
  output logic [9:0] line_len,
  output logic [9:0] frame_lines,
  output logic       frame_start,
  output logic       timing_err
);

  localparam int H_TOTAL = H_DISPLAY + H_BACK + H_FRONT + H_SYNC;
  localparam int V_TOTAL = V_DISPLAY + V_TOP + V_BOTTOM + V_SYNC;

  localparam logic [9:0] CNT_MAX     = 10'd1023;
  localparam logic [9:0] H_TOTAL_W   = 10'(H_TOTAL);
  localparam logic [9:0] V_LAST_W    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_W    = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_W    = 10'(V_SYNC);
  localparam logic [9:0] H_ACT_FIRST = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_ACT_LAST  = 10'(H_SYNC + H_BACK + H_DISPLAY - 1);
  localparam logic [9:0] V_ACT_FIRST = 10'(V_SYNC + V_BOTTOM);
  localparam logic [9:0] V_ACT_LAST  = 10'(V_SYNC + V_BOTTOM + V_DISPLAY - 1);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t     state, state_next;
  logic [2:0] good, good_next;

  logic       hs_q, hs_qq, vs_q, vs_qq;
  logic [9:0] hcnt, vcnt, hsw, vsw;
  logic       vpend, frame_err, skip_line;

  logic hfall, hrise, vfall, vrise, boundary;
  logic hlen_err, hsw_err, vsw_err, line_err, timeout, frame_good;

  assign hfall    = hs_qq & ~hs_q;
  assign hrise    = ~hs_qq & hs_q;
  assign vfall    = vs_qq & ~vs_q;
  assign vrise    = ~vs_qq & vs_q;
  assign boundary = hfall & (vpend | vfall);

  // skip_line exempts the first line after leaving SEARCH, whose length is arbitrary
  assign hlen_err   = hfall & (hcnt != H_TOTAL_W) & ~skip_line;
  assign hsw_err    = hrise & (hsw != H_SYNC_W);
  assign vsw_err    = vrise & (vsw != V_SYNC_W);
  assign timeout    = (hcnt == CNT_MAX) | (vcnt == CNT_MAX);
  assign line_err   = hlen_err | hsw_err | (hcnt == CNT_MAX);
  assign frame_good = (vcnt == V_LAST_W) & ~frame_err & ~line_err & ~vsw_err;

  assign hpos        = hfall ? 10'd0 : hcnt;
  assign vpos        = vcnt;
  assign frame_start = boundary;
  assign locked      = (state == LOCKED);
  assign display_on  = locked & (hpos >= H_ACT_FIRST) & (hpos <= H_ACT_LAST)
                     & (vpos >= V_ACT_FIRST) & (vpos <= V_ACT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hs_q        <= 1'b1;
      hs_qq       <= 1'b1;
      vs_q        <= 1'b1;
      vs_qq       <= 1'b1;
      hcnt        <= '0;
      vcnt        <= '0;
      hsw         <= '0;
      vsw         <= '0;
      vpend       <= 1'b0;
      frame_err   <= 1'b0;
      skip_line   <= 1'b0;
      line_len    <= '0;
      frame_lines <= '0;
      state       <= SEARCH;
      good        <= '0;
    end else begin
      hs_q  <= hsync;
      hs_qq <= hs_q;
      vs_q  <= vsync;
      vs_qq <= vs_q;

      if (hfall) begin
        hcnt     <= 10'd1;
        line_len <= hcnt;
      end else if (hcnt != CNT_MAX) begin
        hcnt <= hcnt + 10'd1;
      end

      if (hrise)
        hsw <= '0;
      else if (!hs_q && hsw != CNT_MAX)
        hsw <= hsw + 10'd1;

      if (boundary) begin
        vcnt        <= '0;
        frame_lines <= vcnt + 10'd1;
      end else if (hfall && vcnt != CNT_MAX) begin
        vcnt <= vcnt + 10'd1;
      end

      if (boundary)
        vpend <= 1'b0;
      else if (vfall)
        vpend <= 1'b1;

      if (vrise)
        vsw <= '0;
      else if (hfall && !vs_q && vsw != CNT_MAX)
        vsw <= vsw + 10'd1;

      // errors seen on a boundary cycle belong to the frame being closed
      if (boundary)
        frame_err <= 1'b0;
      else
        frame_err <= frame_err | line_err | vsw_err;

      if (state == SEARCH)
        skip_line <= 1'b1;
      else if (hfall)
        skip_line <= 1'b0;

      state <= state_next;
      good  <= good_next;
    end
  end

  always_comb begin
    state_next = state;
    good_next  = good;
    timing_err = 1'b0;
    if (timeout && state != SEARCH) begin
      state_next = SEARCH;
      good_next  = '0;
      timing_err = 1'b1;
    end else begin
      case (state)
        SEARCH: begin
          if (boundary) begin
            state_next = VERIFY;
            good_next  = '0;
          end
        end
        VERIFY: begin
          if (line_err || vsw_err)
            timing_err = 1'b1;
          if (boundary) begin
            if (frame_good) begin
              good_next = good + 3'd1;
              if (int'(good) + 1 >= LOCK_FRAMES)
                state_next = LOCKED;
            end else begin
              good_next  = '0;
              timing_err = 1'b1;
            end
          end
        end
        LOCKED: begin
          if (vsw_err)
            timing_err = 1'b1;
          if (line_err || (boundary && !frame_good)) begin
            state_next = VERIFY;
            good_next  = '0;
            timing_err = 1'b1;
          end
        end
        default: begin
          state_next = SEARCH;
          good_next  = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga640x480_sync_rx.sv
// Directed bench for vga640x480_sync_rx using a shrunken 28x15 timing so that
// lock, error, timeout, vsync-width and reset scenarios fit in a short run.
module tb_vga640x480_sync_rx;

  localparam int HD = 16, HB = 4, HF = 2, HS = 6;
  localparam int VD = 8, VTOP = 2, VB = 3, VS = 2;
  localparam int HT = HD + HB + HF + HS;
  localparam int VT = VD + VTOP + VB + VS;
  localparam int DISP_PER_FRAME = HD * VD;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       hsync = 1'b1;
  logic       vsync = 1'b1;
  logic       locked, display_on, frame_start, timing_err;
  logic [9:0] hpos, vpos, line_len, frame_lines;

  int checks = 0;
  int fails  = 0;

  int cyc = 0, disp_cnt = 0, te_cnt = 0, te_cyc = -1;
  int lock_rises = 0, lock_rise_cyc = -1, lock_fall_cyc = -1;
  int fs_cyc_q[$];
  int disp_snap_q[$];
  logic prev_locked = 1'b0;
  int lock_base;

  always #5 clk = ~clk;

  vga640x480_sync_rx #(
    .H_DISPLAY(HD), .H_BACK(HB), .H_FRONT(HF), .H_SYNC(HS),
    .V_DISPLAY(VD), .V_TOP(VTOP), .V_BOTTOM(VB), .V_SYNC(VS),
    .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
    .locked(locked), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .line_len(line_len), .frame_lines(frame_lines),
    .frame_start(frame_start), .timing_err(timing_err)
  );

  // Event recorder on the falling edge, away from the DUT's active edge
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (frame_start) begin
      fs_cyc_q.push_back(cyc);
      disp_snap_q.push_back(disp_cnt);
    end
    if (display_on) disp_cnt <= disp_cnt + 1;
    if (timing_err) begin
      te_cnt <= te_cnt + 1;
      te_cyc <= cyc;
    end
    if (locked && !prev_locked) begin
      lock_rises    <= lock_rises + 1;
      lock_rise_cyc <= cyc;
    end
    if (!locked && prev_locked) lock_fall_cyc <= cyc;
    prev_locked <= locked;
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic driveCycle(input logic h, input logic v);
    @(posedge clk);
    #1;
    hsync = h;
    vsync = v;
  endtask

  task automatic applyStimulus(input int len, input int hw, input logic vlow);
    for (int j = 0; j < len; j++)
      driveCycle((j < hw) ? 1'b0 : 1'b1, ~vlow);
  endtask

  task automatic sendFrame(input int bad_line, input int bad_len, input int bad_hsw, input int vs_lines);
    for (int l = 0; l < VT; l++) begin
      if (l == bad_line)
        applyStimulus(bad_len, bad_hsw, l < vs_lines);
      else
        applyStimulus(HT, HS, l < vs_lines);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_locked"}, int'(locked), 0);
    checkOutput({tag, "_hpos"}, int'(hpos), 0);
    checkOutput({tag, "_vpos"}, int'(vpos), 0);
    checkOutput({tag, "_display_on"}, int'(display_on), 0);
    checkOutput({tag, "_line_len"}, int'(line_len), 0);
    checkOutput({tag, "_frame_lines"}, int'(frame_lines), 0);
    checkOutput({tag, "_frame_start"}, int'(frame_start), 0);
    checkOutput({tag, "_timing_err"}, int'(timing_err), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    reset = 1'b1;

    // nominal stream: lock one clock after the 3rd frame_start
    repeat (4) sendFrame(-1, HT, HS, VS);
    checkOutput("fs_count_nominal", fs_cyc_q.size(), 4);
    checkOutput("line_len_nominal", int'(line_len), HT);
    checkOutput("frame_lines_nominal", int'(frame_lines), VT);
    checkOutput("locked_nominal", int'(locked), 1);
    checkOutput("te_nominal", te_cnt, 0);
    if (fs_cyc_q.size() >= 4) begin
      checkOutput("lock_latency", lock_rise_cyc - fs_cyc_q[2], 1);
      checkOutput("display_count", disp_snap_q[3] - disp_snap_q[2], DISP_PER_FRAME);
    end

    // one short hsync pulse while locked
    sendFrame(4, HT, HS - 1, VS);
    checkOutput("te_short_hsync", te_cnt, 1);
    checkOutput("lock_drop_latency", lock_fall_cyc - te_cyc, 1);
    checkOutput("locked_after_short", int'(locked), 0);
    sendFrame(-1, HT, HS, VS);
    checkOutput("te_bad_frame", te_cnt, 2);
    sendFrame(-1, HT, HS, VS);
    checkOutput("locked_one_good", int'(locked), 0);
    sendFrame(-1, HT, HS, VS);
    checkOutput("relocked_short", int'(locked), 1);

    // one over-long line while locked
    for (int l = 0; l < VT; l++) begin
      applyStimulus((l == 6) ? HT + 1 : HT, HS, l < VS);
      if (l == 7) begin
        checkOutput("line_len_long", int'(line_len), HT + 1);
        checkOutput("te_long_line", te_cnt, 3);
        checkOutput("locked_long_line", int'(locked), 0);
      end
    end
    sendFrame(-1, HT, HS, VS);
    checkOutput("te_long_frame", te_cnt, 4);
    checkOutput("frame_lines_long", int'(frame_lines), VT);
    sendFrame(-1, HT, HS, VS);
    sendFrame(-1, HT, HS, VS);
    checkOutput("relocked_long", int'(locked), 1);

    // hsync stuck high: saturate and time out once
    repeat (1100) driveCycle(1'b1, 1'b1);
    checkOutput("hpos_saturated", int'(hpos), 1023);
    checkOutput("te_timeout", te_cnt, 5);
    checkOutput("locked_timeout", int'(locked), 0);
    checkOutput("display_timeout", int'(display_on), 0);

    // 3-line vsync frame is rejected, lock never reached meanwhile
    lock_base = lock_rises;
    sendFrame(-1, HT, HS, VS);
    sendFrame(-1, HT, HS, 3);
    checkOutput("te_vsync_width", te_cnt, 6);
    sendFrame(-1, HT, HS, VS);
    checkOutput("te_vsync_frame", te_cnt, 7);
    sendFrame(-1, HT, HS, VS);
    checkOutput("no_lock_vsync", lock_rises - lock_base, 0);
    sendFrame(-1, HT, HS, VS);
    checkOutput("locked_before_reset", int'(locked), 1);

    // asynchronous reset in the middle of the active area
    for (int l = 0; l < 7; l++) applyStimulus(HT, HS, l < VS);
    for (int j = 0; j < 20; j++) driveCycle((j < HS) ? 1'b0 : 1'b1, 1'b1);
    checkOutput("display_mid_frame", int'(display_on), 1);
    #2;
    reset = 1'b0;
    #1;
    checkResetOutputs("async_reset");
    for (int j = 20; j < HT; j++) driveCycle(1'b1, 1'b1);
    reset = 1'b1;
    for (int l = 8; l < VT; l++) applyStimulus(HT, HS, 1'b0);
    sendFrame(-1, HT, HS, VS);
    checkOutput("relock_g", int'(locked), 0);
    sendFrame(-1, HT, HS, VS);
    checkOutput("relock_h", int'(locked), 0);
    sendFrame(-1, HT, HS, VS);
    checkOutput("relock_i", int'(locked), 1);
    if (fs_cyc_q.size() > 0)
      checkOutput("relock_latency", lock_rise_cyc - fs_cyc_q[fs_cyc_q.size() - 1], 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
